multicycle_control: RTL and testbench

Parametrised multi-cycle MIPS control unit. A Moore state machine sequences instruction fetch, decode, execute, memory access and write-back, and drives every datapath select/enable. The ALU operation is decoded internally. It supports R-type, lw, sw, beq, bne, addi and j, configurable memory wait states, and a sticky illegal-instruction trap. It sits between the instruction register (op/funct) and the multi-cycle datapath.

---
 rtl/multicycle_control.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back, and drives every datapath select/enable.
// Memory states (fetch, load, store) stretch over MEM_WAIT+1 cycles using a
// small wait counter; unknown opcodes or functs land in a sticky TRAP state.
module multicycle_control #(
  parameter int MEM_WAIT = 0,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcWriteCond,
  output logic               pcWrite,
  output logic               pcEn,
  output logic               iOrD,
  output logic               memRead,
  output logic               memWrite,
  output logic               memToReg,
  output logic               irWrite,
  output logic [1:0]         pcSource,
  output logic [1:0]         aluSrcB,
  output logic               aluSrcA,
  output logic               regWrite,
  output logic               regDst,
  output logic [2:0]         aluControl,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic       lastCycle;
  logic       functOk;
  logic [2:0] functAlu;
  logic       isBne;

  assign lastCycle = (waitCnt_q == WAIT_MAX);
  assign isBne     = (op == OP_BNE);

  // Translate the R-type funct field into an ALU operation and flag unknown ones
  always_comb begin
    functOk  = 1'b1;
    functAlu = ALU_AND;
    case (funct)
      6'b100000: functAlu = ALU_ADD;
      6'b100010: functAlu = ALU_SUB;
      6'b100100: functAlu = ALU_AND;
      6'b100101: functAlu = ALU_OR;
      6'b101010: functAlu = ALU_SLT;
      default:   functOk  = 1'b0;
    endcase
  end

  // Next-state and wait-counter logic; the counter only runs in memory states
  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    case (state_q)
      S_FETCH: begin
        if (lastCycle) state_d = S_DECODE;
        else           waitCnt_d = waitCnt_q + 4'd1;
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (lastCycle) state_d = S_MEMWB;
        else           waitCnt_d = waitCnt_q + 4'd1;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (lastCycle) state_d = S_FETCH;
        else           waitCnt_d = waitCnt_q + 4'd1;
      end
      S_EXEC:   state_d = functOk ? S_ALUWB : S_TRAP;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // State and wait-counter registers; reset restarts at fetch immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Moore outputs decoded from the current state (and wait counter in fetch)
  always_comb begin
    pcWriteCond = 1'b0;
    pcWrite     = 1'b0;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    irWrite     = 1'b0;
    pcSource    = 2'b00;
    aluSrcB     = 2'b00;
    aluSrcA     = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    aluControl  = 3'b000;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead    = 1'b1;
        aluSrcB    = 2'b01;
        aluControl = ALU_ADD;
        irWrite    = lastCycle;
        pcWrite    = lastCycle;
      end
      S_DECODE: begin
        aluSrcB    = 2'b11;
        aluControl = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        aluControl = ALU_ADD;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
      end
      S_EXEC: begin
        aluSrcA    = 1'b1;
        aluControl = functAlu;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluControl  = ALU_SUB;
        pcSource    = 2'b01;
        pcWriteCond = 1'b1;
      end
      S_ADDIWB: regWrite = 1'b1;
      S_JUMP: begin
        pcSource = 2'b10;
        pcWrite  = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // bne takes the branch when the ALU result is non-zero, beq when it is zero
  assign pcEn  = pcWrite | (pcWriteCond & (zero ^ isBne));
  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Three instances with
// MEM_WAIT = 0, 1, 2 are exercised one at a time (the others held in reset).
// A reference model expands each instruction into its expected sequence of
// control-unit cycles and checks every output every cycle.
module tb_multicycle_control;

  typedef struct {
    int code;
    bit last;
  } step_t;

  logic       clk;
  logic [2:0] rstVec;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [22:0] vec [3];
  logic [22:0] obs;
  int          sel;
  int          waitCur;
  int          checkCount;
  int          passCount;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gDut
      logic pcWriteCond, pcWrite, pcEn, iOrD, memRead, memWrite, memToReg, irWrite;
      logic [1:0] pcSource, aluSrcB;
      logic aluSrcA, regWrite, regDst, illegal;
      logic [2:0] aluControl;
      logic [3:0] state;

      multicycle_control #(.MEM_WAIT(g), .STATE_W(4)) dut (
        .clk(clk), .reset(rstVec[g]), .op(op), .funct(funct), .zero(zero),
        .pcWriteCond(pcWriteCond), .pcWrite(pcWrite), .pcEn(pcEn), .iOrD(iOrD),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .irWrite(irWrite), .pcSource(pcSource), .aluSrcB(aluSrcB),
        .aluSrcA(aluSrcA), .regWrite(regWrite), .regDst(regDst),
        .aluControl(aluControl), .illegal(illegal), .state(state)
      );

      assign vec[g] = {pcWriteCond, pcWrite, pcEn, iOrD, memRead, memWrite,
                       memToReg, irWrite, pcSource, aluSrcB, aluSrcA,
                       regWrite, regDst, aluControl, illegal, state};
    end
  endgenerate

  // Route the outputs of the instance under test to the checker
  always_comb begin
    case (sel)
      0:       obs = vec[0];
      1:       obs = vec[1];
      default: obs = vec[2];
    endcase
  end

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Valid R-type funct codes and their ALU operation
  function automatic bit functValid(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) ||
           (f == 6'h25) || (f == 6'h2A);
  endfunction

  // Expected output vector for one control-unit cycle, straight from the state table
  function automatic logic [22:0] expVec(input int code, input bit last,
                                         input logic [5:0] o, input logic [5:0] f,
                                         input logic z);
    logic pwc, pw, pe, iod, mr, mw, m2r, irw, srcA, rw, rd, ill;
    logic [1:0] psrc, srcB;
    logic [2:0] alu;
    {pwc, pw, iod, mr, mw, m2r, irw, srcA, rw, rd, ill} = '0;
    psrc = 2'd0; srcB = 2'd0; alu = 3'd0;
    case (code)
      0:  begin mr = 1; srcB = 2'd1; alu = 3'b010; irw = last; pw = last; end
      1:  begin srcB = 2'd3; alu = 3'b010; end
      2:  begin srcA = 1; srcB = 2'd2; alu = 3'b010; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin
            srcA = 1;
            case (f)
              6'h20: alu = 3'b010;
              6'h22: alu = 3'b110;
              6'h24: alu = 3'b000;
              6'h25: alu = 3'b001;
              6'h2A: alu = 3'b111;
              default: alu = 3'b000;
            endcase
          end
      7:  begin rw = 1; rd = 1; end
      8:  begin srcA = 1; alu = 3'b110; psrc = 2'd1; pwc = 1; end
      9:  begin srcA = 1; srcB = 2'd2; alu = 3'b010; end
      10: rw = 1;
      11: begin psrc = 2'd2; pw = 1; end
      default: ill = 1;
    endcase
    pe = pw | (pwc & (z ^ (o == 6'h05)));
    return {pwc, pw, pe, iod, mr, mw, m2r, irw, psrc, srcB, srcA, rw, rd, alu,
            ill, 4'(code)};
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h (MEM_WAIT=%0d op=%b funct=%b zero=%b)",
                  tag, got, want, waitCur, op, funct, zero);
  endtask

  // Expand one instruction into the cycles it must take
  function automatic void buildSteps(input logic [5:0] o, input logic [5:0] f,
                                     input int w, ref step_t q[$]);
    bit toTrap = 0;
    q.delete();
    for (int i = 0; i <= w; i++) q.push_back('{0, i == w});
    q.push_back('{1, 0});
    case (o)
      6'h00: begin
        q.push_back('{6, 0});
        if (functValid(f)) q.push_back('{7, 0});
        else toTrap = 1;
      end
      6'h23: begin
        q.push_back('{2, 0});
        for (int i = 0; i <= w; i++) q.push_back('{3, 0});
        q.push_back('{4, 0});
      end
      6'h2B: begin
        q.push_back('{2, 0});
        for (int i = 0; i <= w; i++) q.push_back('{5, 0});
      end
      6'h04, 6'h05: q.push_back('{8, 0});
      6'h08: begin q.push_back('{9, 0}); q.push_back('{10, 0}); end
      6'h02: q.push_back('{11, 0});
      default: toTrap = 1;
    endcase
    if (toTrap) for (int i = 0; i < 20; i++) q.push_back('{15, 0});
  endfunction

  // Run one instruction on the selected instance and check every cycle.
  // abortAt >= 0 asserts reset asynchronously in that cycle instead.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input int abortAt);
    step_t q[$];
    logic [22:0] mask;
    op = o; funct = f; zero = z;
    buildSteps(o, f, waitCur, q);
    foreach (q[i]) begin
      mask = '1;
      if (q[i].code == 6 && !functValid(f)) mask[7:5] = 3'b000;
      if (i == abortAt) begin
        #1 checkOutput("preabort", obs, expVec(q[i].code, q[i].last, op, funct, zero));
        #1 rstVec[sel] = 1'b1;
        #1 checkOutput("abort", obs, expVec(0, waitCur == 0, op, funct, zero));
        @(posedge clk); #1 rstVec[sel] = 1'b0;
        return;
      end
      @(negedge clk);
      checkOutput($sformatf("s%0d", q[i].code), obs & mask,
                  expVec(q[i].code, q[i].last, op, funct, zero) & mask);
      if (q[i].code == 8) begin
        zero = ~zero;
        #1 checkOutput("pcEnFlip", obs, expVec(8, 0, op, funct, zero));
        zero = ~zero;
      end
      @(posedge clk); #1;
    end
    if (q[q.size()-1].code == 15) begin
      rstVec[sel] = 1'b1;
      #1 checkOutput("trapReset", obs, expVec(0, waitCur == 0, op, funct, zero));
      @(posedge clk); #1 rstVec[sel] = 1'b0;
    end
  endtask

  initial begin
    logic [5:0] opTab [8];
    logic [5:0] fnTab [5];
    logic [5:0] ro, rf;
    int k;
    opTab = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
    fnTab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    checkCount = 0; passCount = 0;
    rstVec = 3'b111; op = '0; funct = '0; zero = 1'b0; sel = 0; waitCur = 0;

    for (int s = 0; s < 3; s++) begin
      sel = s; waitCur = s;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("reset", obs, expVec(0, waitCur == 0, op, funct, zero));
      @(posedge clk); #1 rstVec[sel] = 1'b0;

      applyStimulus(6'h00, 6'h22, 1'b0, -1);
      applyStimulus(6'h23, 6'h00, 1'b0, -1);
      applyStimulus(6'h2B, 6'h00, 1'b1, -1);
      applyStimulus(6'h04, 6'h00, 1'b1, -1);
      applyStimulus(6'h04, 6'h00, 1'b0, -1);
      applyStimulus(6'h05, 6'h00, 1'b1, -1);
      applyStimulus(6'h05, 6'h00, 1'b0, -1);
      applyStimulus(6'h08, 6'h00, 1'b0, -1);
      applyStimulus(6'h02, 6'h00, 1'b0, -1);
      applyStimulus(6'h3F, 6'h00, 1'b0, -1);
      applyStimulus(6'h00, 6'h00, 1'b0, -1);
      if (s == 1) begin
        // second MEMWR cycle of sw with MEM_WAIT=1 is step index 5
        applyStimulus(6'h2B, 6'h00, 1'b0, 5);
        applyStimulus(6'h00, 6'h20, 1'b0, -1);
      end

      for (int n = 0; n < 25; n++) begin
        k  = $urandom_range(0, 9);
        rf = fnTab[$urandom_range(0, 4)];
        if (k < 8) ro = opTab[k];
        else if (k == 8) ro = 6'($urandom_range(0, 63));
        else begin ro = 6'h00; rf = 6'($urandom_range(0, 63)); end
        applyStimulus(ro, rf, 1'($urandom_range(0, 1)), -1);
      end
      rstVec[sel] = 1'b1;
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
